// File: rtl/sprite_commit_ctrl.sv
// Sprite object table controller: host-written staging table, committed
// atomically into the active table one sprite per cycle at vsync rise.
module sprite_commit_ctrl #(
  parameter int unsigned MAX_SPRITES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [5:0]                 address,
  input  logic [31:0]                data_in,
  input  logic [1:0]                 data_write_n,
  input  logic [1:0]                 data_read_n,
  output logic [31:0]                data_out,
  output logic                       data_ready,
  input  logic                       vsync,
  output logic [32*MAX_SPRITES-1:0]  active_obj,
  output logic                       busy,
  output logic                       user_interrupt
);

  localparam int unsigned STAGE_BYTES = 4 * MAX_SPRITES;
  localparam logic [2:0]  IDX_LAST    = 3'(MAX_SPRITES - 1);
  localparam logic [6:0]  A_CTRL      = 7'h20;
  localparam logic [6:0]  A_STATUS    = 7'h21;
  localparam logic [6:0]  A_FRAMES    = 7'h22;

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [8*STAGE_BYTES-1:0] stage_q, stage_d;
  logic [3:0]               ctrl_q, ctrl_d;   // {ENABLE, IRQ_COMMIT_EN, IRQ_MISS_EN, STAGE_READY}
  logic [2:0]               status_q;         // {WR_DROP, COMMITTED, MISS}
  logic [2:0]               status_set, status_w1c;
  logic [7:0]               frames_q;
  logic                     vsync_d, vsync_rise;
  logic                     miss_set, copy_en, commit_done, wr_drop;
  logic [2:0]               wr_lanes, rd_lanes;
  logic [6:0]               wr_addr, rd_addr;
  logic [7:0]               wr_byte;
  logic [31:0]              rd_data;

  function automatic logic [2:0] lane_count(input logic [1:0] code);
    case (code)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  assign wr_lanes   = lane_count(data_write_n);
  assign rd_lanes   = lane_count(data_read_n);
  assign vsync_rise = ctrl_q[3] & vsync & ~vsync_d;
  assign busy       = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    miss_set    = 1'b0;
    copy_en     = 1'b0;
    commit_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vsync_rise) begin
          if (ctrl_q[0]) begin
            state_d = S_COPY;
            idx_d   = '0;
          end else begin
            miss_set = 1'b1;
          end
        end
      end
      S_COPY: begin
        copy_en = 1'b1;
        if (idx_q == IDX_LAST) state_d = S_DONE;
        else                   idx_d   = idx_q + 3'd1;
      end
      S_DONE: begin
        commit_done = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte-lane write decode; staging lanes are refused while a commit is running.
  always_comb begin
    stage_d    = stage_q;
    ctrl_d     = ctrl_q;
    status_w1c = '0;
    wr_drop    = 1'b0;
    wr_addr    = '0;
    wr_byte    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < 32'(wr_lanes)) begin
        wr_addr = {1'b0, address} + 7'(k);
        wr_byte = data_in[8*k +: 8];
        if (32'(wr_addr) < STAGE_BYTES) begin
          if (busy) wr_drop = 1'b1;
          else      stage_d[8*wr_addr +: 8] = wr_byte;
        end else if (wr_addr == A_CTRL) begin
          ctrl_d = wr_byte[3:0];
        end else if (wr_addr == A_STATUS) begin
          status_w1c = wr_byte[2:0];
        end
      end
    end
  end

  assign status_set = {wr_drop, commit_done, miss_set};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q        <= '0;
      ctrl_q         <= '0;
      status_q       <= '0;
      frames_q       <= '0;
      active_obj     <= '0;
      vsync_d        <= 1'b0;
      user_interrupt <= 1'b0;
    end else begin
      vsync_d  <= vsync;
      stage_q  <= stage_d;
      // DONE's hardware clear of STAGE_READY wins over a same-cycle host set
      ctrl_q   <= commit_done ? {ctrl_d[3:1], 1'b0} : ctrl_d;
      status_q <= (status_q & ~status_w1c) | status_set;
      if (commit_done) frames_q <= frames_q + 8'd1;
      if (copy_en) active_obj[32*idx_q +: 32] <= stage_q[32*idx_q +: 32];
      user_interrupt <= (status_q[0] & ctrl_q[1]) | (status_q[1] & ctrl_q[2]);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_addr = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < 32'(rd_lanes)) begin
        rd_addr = {1'b0, address} + 7'(k);
        if (32'(rd_addr) < STAGE_BYTES) rd_data[8*k +: 8] = stage_q[8*rd_addr +: 8];
        else if (rd_addr == A_CTRL)     rd_data[8*k +: 8] = {4'b0, ctrl_q};
        else if (rd_addr == A_STATUS)   rd_data[8*k +: 8] = {4'b0, busy, status_q};
        else if (rd_addr == A_FRAMES)   rd_data[8*k +: 8] = frames_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_ready <= 1'b0;
    end else if (rd_lanes != 3'd0) begin
      data_out   <= rd_data;
      data_ready <= 1'b1;
    end else begin
      data_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Self-checking bench for sprite_commit_ctrl: cycle-level behavioural model
// plus directed scenarios with literal expectations and a random phase.
module tb_sprite_commit_ctrl;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [5:0]      address = '0;
  logic [31:0]     data_in = '0;
  logic [1:0]      data_write_n = 2'b11;
  logic [1:0]      data_read_n = 2'b11;
  logic            vsync = 1'b0;
  logic [31:0]     data_out;
  logic            data_ready;
  logic [32*N-1:0] active_obj;
  logic            busy;
  logic            user_interrupt;

  always #5 clk = ~clk;

  sprite_commit_ctrl #(.MAX_SPRITES(N)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .vsync(vsync),
    .active_obj(active_obj), .busy(busy), .user_interrupt(user_interrupt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_stage [4*N];
  logic [31:0] m_act [N];
  logic [3:0]  m_ctrl;
  logic        m_miss, m_comm, m_drop;
  logic [7:0]  m_frames;
  logic [31:0] m_dout;
  logic        m_drdy, m_irq;
  logic        m_vs_prev;
  int          m_commit_e = -1;   // cycle of the accepted edge, -1 when idle
  int          cyc = 0;
  bit          m_bsy, m_rise, m_ready_pre, m_miss_set, m_done, m_dropped;
  logic [2:0]  m_w1c;
  int          m_p, m_a;
  logic [7:0]  m_byte;

  function automatic int lanes(input logic [1:0] c);
    case (c)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] m_read_byte(input int a, input bit bsy);
    if (a < 4*N) return m_stage[a];
    if (a == 32) return {4'b0, m_ctrl};
    if (a == 33) return {4'b0, bsy, m_drop, m_comm, m_miss};
    if (a == 34) return m_frames;
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4*N; i++) m_stage[i] = '0;
      for (int i = 0; i < N; i++) m_act[i] = '0;
      m_ctrl = '0; m_miss = 0; m_comm = 0; m_drop = 0; m_frames = '0;
      m_dout = '0; m_drdy = 0; m_irq = 0; m_vs_prev = 0;
      m_commit_e = -1; cyc = 0;
    end else begin
      m_bsy       = (m_commit_e >= 0);
      m_ready_pre = m_ctrl[0];
      m_irq       = (m_miss & m_ctrl[1]) | (m_comm & m_ctrl[2]);
      if (lanes(data_read_n) > 0) begin
        m_dout = '0;
        for (int k = 0; k < lanes(data_read_n); k++)
          m_dout[8*k +: 8] = m_read_byte(int'(address) + k, m_bsy);
        m_drdy = 1;
      end else begin
        m_drdy = 0;
      end
      m_rise    = m_ctrl[3] && vsync && !m_vs_prev;
      m_w1c     = '0;
      m_dropped = 0;
      for (int k = 0; k < lanes(data_write_n); k++) begin
        m_a    = int'(address) + k;
        m_byte = data_in[8*k +: 8];
        if (m_a < 4*N) begin
          if (m_bsy) m_dropped = 1;
          else       m_stage[m_a] = m_byte;
        end else if (m_a == 32) m_ctrl = m_byte[3:0];
        else if (m_a == 33)     m_w1c  = m_byte[2:0];
      end
      m_miss_set = 0;
      m_done     = 0;
      if (m_bsy) begin
        m_p = cyc - m_commit_e;
        if (m_p <= N)
          m_act[m_p-1] = {m_stage[4*(m_p-1)+3], m_stage[4*(m_p-1)+2],
                          m_stage[4*(m_p-1)+1], m_stage[4*(m_p-1)]};
        else begin
          m_done = 1;
          m_commit_e = -1;
        end
      end else if (m_rise) begin
        if (m_ready_pre) m_commit_e = cyc;
        else             m_miss_set = 1;
      end
      if (m_done) begin
        m_ctrl[0] = 0;
        m_frames  = m_frames + 8'd1;
      end
      m_miss    = (m_miss & ~m_w1c[0]) | m_miss_set;
      m_comm    = (m_comm & ~m_w1c[1]) | m_done;
      m_drop    = (m_drop & ~m_w1c[2]) | m_dropped;
      m_vs_prev = vsync;
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  logic [32*N-1:0] exp_act;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) exp_act[32*i +: 32] = m_act[i];
      check("data_ready", data_ready, m_drdy);
      check("data_out", data_out, m_dout);
      check("busy", busy, m_commit_e >= 0);
      check("user_interrupt", user_interrupt, m_irq);
      check("active_obj", active_obj, exp_act);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address = a; data_in = d; data_write_n = sz;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, input logic [1:0] sz, output logic [31:0] v);
    address = a; data_read_n = sz;
    tick();
    data_read_n = 2'b11;
    v = data_out;
  endtask

  task automatic pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  logic [31:0] v;
  logic [31:0] spr1;

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_en = 1;
    check("rst_active", active_obj, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_irq", user_interrupt, 1'b0);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_data_out", data_out, 32'h0);

    // Commit of sprite 1
    wr(6'h20, 32'h08, 2'b00);
    wr(6'h04, 32'h84211040, 2'b10);
    wr(6'h20, 32'h09, 2'b00);
    pulse();                                   // now E+1
    check("commit_busy_e1", busy, 1'b1);
    tick(); tick();                            // now E+3
    spr1 = active_obj[63:32];
    check("commit_sprite1", spr1, 32'h84211040);
    tick(); tick(); tick();                    // now E+6
    check("commit_busy_e6", busy, 1'b0);
    rd(6'h20, 2'b10, v);
    check("commit_regs32", v, 32'h0001_0208);
    check("commit_rd_ready", data_ready, 1'b1);

    // Miss with interrupt
    wr(6'h20, 32'h0A, 2'b00);
    pulse();                                   // E+1
    check("miss_irq_e1", user_interrupt, 1'b0);
    tick();                                    // E+2
    check("miss_irq_e2", user_interrupt, 1'b1);
    wr(6'h21, 32'h01, 2'b00);                  // E+3
    check("miss_irq_hold", user_interrupt, 1'b1);
    tick();
    check("miss_irq_drop", user_interrupt, 1'b0);
    spr1 = active_obj[63:32];
    check("miss_active_kept", spr1, 32'h84211040);

    // Dropped staging write during COPY
    wr(6'h20, 32'h09, 2'b00);
    pulse();
    wr(6'h00, 32'hFF, 2'b00);
    repeat (4) tick();
    rd(6'h00, 2'b00, v);
    check("drop_stage_byte", v, 32'h0);
    rd(6'h21, 2'b00, v);
    check("drop_status", v, 32'h06);
    wr(6'h1F, 32'h0000_0A55, 2'b01);
    rd(6'h20, 2'b00, v);
    check("split_ctrl", v, 32'h0A);
    wr(6'h21, 32'h07, 2'b00);

    // STAGE_READY written in the edge cycle: miss now, commit next frame
    address = 6'h20; data_in = 32'h0B; data_write_n = 2'b00; vsync = 1'b1;
    tick();
    data_write_n = 2'b11; vsync = 1'b0;
    check("coll_no_busy", busy, 1'b0);
    tick();
    rd(6'h21, 2'b00, v);
    check("coll_miss", v, 32'h01);
    pulse();                                   // E+1
    check("coll_next_busy", busy, 1'b1);
    repeat (4) tick();                         // E+5 = DONE
    wr(6'h21, 32'h02, 2'b00);
    rd(6'h21, 2'b00, v);
    check("coll_w1c_in_done", v, 32'h03);
    rd(6'h22, 2'b00, v);
    check("frames_3", v, 32'h03);

    // Reset in the middle of COPY
    wr(6'h21, 32'h07, 2'b00);
    wr(6'h20, 32'h09, 2'b00);
    pulse();                                   // E+1
    tick();                                    // E+2
    rst_n = 1'b0;
    #1;
    check("mid_rst_active", active_obj, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_irq", user_interrupt, 1'b0);
    check("mid_rst_dout", data_out, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    wr(6'h20, 32'h08, 2'b00);
    pulse();
    tick();
    rd(6'h21, 2'b00, v);
    check("post_rst_miss", v, 32'h01);
    rd(6'h22, 2'b00, v);
    check("post_rst_frames", v, 32'h0);

    // FRAMES wrap
    for (int i = 0; i < 256; i++) begin
      wr(6'h20, 32'h09, 2'b00);
      pulse();
      repeat (N+1) tick();
      if (i == 127) begin
        rd(6'h22, 2'b00, v);
        check("frames_128", v, 32'h80);
      end
    end
    rd(6'h22, 2'b00, v);
    check("frames_wrap", v, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) vsync = ~vsync;
      data_write_n = 2'($urandom_range(0, 3));
      data_read_n  = 2'($urandom_range(0, 3));
      address      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 35));
      data_in      = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        address = 6'h20; data_write_n = 2'b00;
        data_in = {24'h0, 4'($urandom), 4'b1001};
      end
      tick();
    end
    data_write_n = 2'b11; data_read_n = 2'b11; vsync = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
